// File: rtl/front_pkg.sv
// rtl/front_pkg.sv - shared constants, state type and pixel helpers for the front line buffer
package front_pkg;

    localparam int         FLB_ADDR_W  = 9;
    localparam int         FLB_DEPTH   = 512;
    localparam logic [7:0] FLB_CLR_VAL = 8'h07;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } flb_state_t;

    // Pen 7 is the transparent pen for every colour bank.
    function automatic logic is_transparent(input logic [2:0] pen);
        return pen == 3'b111;
    endfunction

endpackage

// File: rtl/flb_bank_ram.sv
// rtl/flb_bank_ram.sv - 512x8 true dual-port RAM, read-first, one clock read latency
module flb_bank_ram
    import front_pkg::*;
(
    input  logic                  clk,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [FLB_ADDR_W-1:0] a_addr,
    input  logic [7:0]            a_wdata,
    output logic [7:0]            a_rdata,
    input  logic                  b_en,
    input  logic                  b_we,
    input  logic [FLB_ADDR_W-1:0] b_addr,
    input  logic [7:0]            b_wdata,
    output logic [7:0]            b_rdata
);

    logic [7:0] mem [FLB_DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= mem[a_addr];
            if (a_we) begin
                mem[a_addr] <= a_wdata;
            end
        end
        if (b_en) begin
            b_rdata <= mem[b_addr];
            if (b_we) begin
                mem[b_addr] <= b_wdata;
            end
        end
    end

endmodule

// File: rtl/front_line_buffer.sv
// rtl/front_line_buffer.sv - ping-pong sprite line buffer: composite writes, playback with clear-after-read
module front_line_buffer
    import front_pkg::*;
#(
    parameter int         SPR_W      = 16,
    parameter int         LINE_W     = 256,
    parameter logic [7:0] CLR_VAL    = FLB_CLR_VAL,
    parameter bit         PRIO_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       VIDEO_RST,
    input  logic       pix_cen,
    input  logic       line_swap,
    input  logic       spr_ld,
    input  logic [7:0] FD,
    input  logic [8:0] FL_Y,
    input  logic [8:0] rd_x,
    output logic [7:0] FO,
    output logic       busy
);

    localparam logic [9:0] LINE_LIM = 10'(LINE_W);
    localparam logic [8:0] SPR_LAST = 9'(SPR_W - 1);

    flb_state_t state, state_nxt;
    logic [8:0] clr_addr;
    logic       bank_sel;
    logic [8:0] wr_ptr;
    logic [8:0] wr_cnt;
    logic       wr_active;

    logic       s1_valid, s1_bank, s2_valid, s2_bank;
    logic [8:0] s1_addr, s2_addr;
    logic [7:0] s1_pix, s2_pix;
    logic       r1_valid, r1_bank, r1_inrange, r2_valid, r2_bank, r2_inrange;
    logic [8:0] r1_addr, r2_addr;

    logic       a_en [2];
    logic       a_we [2];
    logic [8:0] a_addr [2];
    logic [7:0] a_wdata [2];
    logic [7:0] a_rdata [2];
    logic       b_en [2];
    logic       b_we [2];
    logic [8:0] b_addr [2];
    logic [7:0] b_rdata [2];

    logic       run, swap_now, sel_eff, pix_go, issue;
    logic [8:0] issue_idx, issue_addr;
    logic [7:0] s2_stored;
    logic       s2_wr, wr_hit, r2_clr;

    assign run        = (state == RUN);
    assign busy       = (state == INIT);
    assign swap_now   = line_swap & run;
    // A swap in the same clock as pix_cen is already visible to both sides.
    assign sel_eff    = bank_sel ^ swap_now;
    assign pix_go     = pix_cen & run;
    assign issue      = pix_go & (spr_ld | wr_active);
    assign issue_idx  = spr_ld ? 9'd0 : wr_cnt + 9'd1;
    assign issue_addr = spr_ld ? FL_Y : wr_ptr + 9'd1;

    assign s2_stored = a_rdata[s2_bank];
    assign s2_wr     = s2_valid && !is_transparent(s2_pix[2:0]) && ({1'b0, s2_addr} < LINE_LIM)
                       && (!PRIO_FIRST || is_transparent(s2_stored[2:0]));
    // A write still draining into the freshly swapped read bank owns that location.
    assign wr_hit    = (s1_valid && s1_bank == r2_bank && s1_addr == r2_addr)
                    || (s2_valid && s2_bank == r2_bank && s2_addr == r2_addr);
    assign r2_clr    = r2_valid && r2_inrange && !wr_hit;

    always_ff @(posedge clk or posedge VIDEO_RST) begin
        if (VIDEO_RST) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (clr_addr == 9'(FLB_DEPTH - 1)) state_nxt = RUN;
            RUN:  state_nxt = RUN;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            a_en[i]    = !run || (s1_valid && s1_bank == 1'(i)) || (s2_wr && s2_bank == 1'(i));
            a_we[i]    = !run || (s2_wr && s2_bank == 1'(i));
            a_addr[i]  = !run ? clr_addr : ((s2_valid && s2_bank == 1'(i)) ? s2_addr : s1_addr);
            a_wdata[i] = !run ? CLR_VAL : s2_pix;
            b_en[i]    = (pix_go && !sel_eff == 1'(i)) || (r2_clr && r2_bank == 1'(i));
            b_we[i]    = r2_clr && r2_bank == 1'(i);
            b_addr[i]  = (r2_clr && r2_bank == 1'(i)) ? r2_addr : rd_x;
        end
    end

    always_ff @(posedge clk or posedge VIDEO_RST) begin
        if (VIDEO_RST) begin
            clr_addr   <= '0;
            bank_sel   <= 1'b0;
            wr_ptr     <= '0;
            wr_cnt     <= '0;
            wr_active  <= 1'b0;
            s1_valid   <= 1'b0;
            s1_bank    <= 1'b0;
            s1_addr    <= '0;
            s1_pix     <= '0;
            s2_valid   <= 1'b0;
            s2_bank    <= 1'b0;
            s2_addr    <= '0;
            s2_pix     <= '0;
            r1_valid   <= 1'b0;
            r1_bank    <= 1'b0;
            r1_addr    <= '0;
            r1_inrange <= 1'b0;
            r2_valid   <= 1'b0;
            r2_bank    <= 1'b0;
            r2_addr    <= '0;
            r2_inrange <= 1'b0;
            FO         <= CLR_VAL;
        end else begin
            if (!run) begin
                clr_addr <= clr_addr + 9'd1;
            end
            if (swap_now) begin
                bank_sel <= ~bank_sel;
            end

            s1_valid <= issue;
            if (issue) begin
                s1_addr   <= issue_addr;
                s1_pix    <= FD;
                s1_bank   <= sel_eff;
                wr_ptr    <= issue_addr;
                wr_cnt    <= issue_idx;
                wr_active <= (issue_idx != SPR_LAST);
            end
            s2_valid <= s1_valid;
            s2_bank  <= s1_bank;
            s2_addr  <= s1_addr;
            s2_pix   <= s1_pix;

            r1_valid <= pix_go;
            if (pix_go) begin
                r1_bank    <= ~sel_eff;
                r1_addr    <= rd_x;
                r1_inrange <= ({1'b0, rd_x} < LINE_LIM);
            end
            r2_valid   <= r1_valid;
            r2_bank    <= r1_bank;
            r2_addr    <= r1_addr;
            r2_inrange <= r1_inrange;
            if (r1_valid) begin
                FO <= r1_inrange ? b_rdata[r1_bank] : CLR_VAL;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        flb_bank_ram u_ram (
            .clk     (clk),
            .a_en    (a_en[g]),
            .a_we    (a_we[g]),
            .a_addr  (a_addr[g]),
            .a_wdata (a_wdata[g]),
            .a_rdata (a_rdata[g]),
            .b_en    (b_en[g]),
            .b_we    (b_we[g]),
            .b_addr  (b_addr[g]),
            .b_wdata (CLR_VAL),
            .b_rdata (b_rdata[g])
        );
    end

endmodule

// File: tb/tb_front_line_buffer.sv
// tb/tb_front_line_buffer.sv - scoreboard bench for front_line_buffer, both priority modes side by side
module tb_front_line_buffer;

    logic       clk = 1'b0;
    logic       VIDEO_RST = 1'b0;
    logic       pix_cen = 1'b0;
    logic       line_swap = 1'b0;
    logic       spr_ld = 1'b0;
    logic [7:0] FD = 8'h00;
    logic [8:0] FL_Y = 9'd0;
    logic [8:0] rd_x = 9'h1FF;
    logic [7:0] fo_p1, fo_p0;
    logic       busy_p1, busy_p0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [8:0] x;
        logic [7:0] e1;
        logic [7:0] e0;
    } exp_t;
    exp_t sb[$];

    logic chk_en = 1'b0;
    logic pend1 = 1'b0;
    logic pend2 = 1'b0;

    front_line_buffer #(.PRIO_FIRST(1'b1)) u_dut_p1 (
        .clk(clk), .VIDEO_RST(VIDEO_RST), .pix_cen(pix_cen), .line_swap(line_swap),
        .spr_ld(spr_ld), .FD(FD), .FL_Y(FL_Y), .rd_x(rd_x), .FO(fo_p1), .busy(busy_p1)
    );

    front_line_buffer #(.PRIO_FIRST(1'b0)) u_dut_p0 (
        .clk(clk), .VIDEO_RST(VIDEO_RST), .pix_cen(pix_cen), .line_swap(line_swap),
        .spr_ld(spr_ld), .FD(FD), .FL_Y(FL_Y), .rd_x(rd_x), .FO(fo_p0), .busy(busy_p0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FO is valid one clock after the pix_cen clock; sample it on the following negedge.
    always @(posedge clk) begin
        pend2 <= pend1;
        pend1 <= pix_cen & chk_en;
    end

    always @(negedge clk) begin
        if (pend2) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("fo_p1 x=%0d", e.x), 32'(fo_p1), 32'(e.e1));
                check($sformatf("fo_p0 x=%0d", e.x), 32'(fo_p0), 32'(e.e0));
            end
        end
    end

    task automatic pix(input logic ld, input logic [7:0] fd, input logic [8:0] fly,
                       input logic [8:0] rdx, input logic sw);
        @(negedge clk);
        pix_cen = 1'b1; spr_ld = ld; FD = fd; FL_Y = fly; rd_x = rdx;
        @(negedge clk);
        pix_cen = 1'b0; spr_ld = 1'b0; line_swap = sw;
        @(negedge clk);
        line_swap = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sprite(input logic [7:0] fd, input logic [8:0] fly, input int n, input logic sw_last);
        for (int i = 0; i < n; i++) begin
            pix(i == 0, fd, fly, 9'h1FF, sw_last && (i == n - 1));
        end
    endtask

    task automatic swap();
        @(negedge clk);
        line_swap = 1'b1;
        @(negedge clk);
        line_swap = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic play(input int lo, input int hi, input logic [7:0] e1, input logic [7:0] e0);
        chk_en = 1'b1;
        for (int x = lo; x <= hi; x++) begin
            sb.push_back('{9'(x), e1, e0});
            pix(1'b0, 8'h00, 9'd0, 9'(x), 1'b0);
        end
        chk_en = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic release_and_sweep(input string tag);
        int cnt;
        check({tag, "_busy_rst"}, 32'(busy_p1), 32'd1);
        check({tag, "_fo_rst"}, 32'(fo_p1), 32'h07);
        @(negedge clk);
        VIDEO_RST = 1'b0;
        cnt = 0;
        while (busy_p1 && cnt < 600) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'd512);
        check({tag, "_busy_p0"}, 32'(busy_p0), 32'd0);
        check({tag, "_fo_after"}, 32'(fo_p0), 32'h07);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 VIDEO_RST = 1'b1;
        repeat (3) @(negedge clk);
        release_and_sweep("rst1");

        // Fresh buffer plays back transparent everywhere.
        play(0, 3, 8'h07, 8'h07);
        play(300, 300, 8'h07, 8'h07);

        // Single sprite, then repeat playback sees the cleared locations.
        sprite(8'h1A, 9'd40, 16, 1'b0);
        swap();
        play(39, 39, 8'h07, 8'h07);
        play(40, 55, 8'h1A, 8'h1A);
        play(56, 56, 8'h07, 8'h07);
        play(40, 55, 8'h07, 8'h07);

        // Overlapping sprites: priority mode decides the overlap.
        sprite(8'h21, 9'd100, 16, 1'b0);
        sprite(8'h32, 9'd108, 16, 1'b0);
        swap();
        play(100, 107, 8'h21, 8'h21);
        play(108, 115, 8'h21, 8'h32);
        play(116, 123, 8'h32, 8'h32);

        // Transparent sprite, and a sprite wrapping from 504 past 511 to 0..7.
        sprite(8'h2F, 9'd10, 16, 1'b0);
        sprite(8'h45, 9'd504, 16, 1'b0);
        swap();
        play(0, 7, 8'h45, 8'h45);
        play(8, 25, 8'h07, 8'h07);

        // Swap one clock after the last pixel: the drain still lands in the old write bank.
        sprite(8'h55, 9'd60, 16, 1'b1);
        play(60, 74, 8'h55, 8'h55);

        // Reset mid-sprite; the last pixel above is read back just before it.
        pix(1'b1, 8'h66, 9'd200, 9'h1FF, 1'b0);
        pix(1'b0, 8'h66, 9'd200, 9'h1FF, 1'b0);
        pix(1'b0, 8'h66, 9'd200, 9'h1FF, 1'b0);
        pix(1'b0, 8'h66, 9'd200, 9'd75, 1'b0);
        check("last_pix_after_swap", 32'(fo_p1), 32'h55);
        #2 VIDEO_RST = 1'b1;
        #1;
        check("mid_rst_fo_p1", 32'(fo_p1), 32'h07);
        check("mid_rst_fo_p0", 32'(fo_p0), 32'h07);
        check("mid_rst_busy", 32'(busy_p0), 32'd1);
        release_and_sweep("rst2");
        play(0, 255, 8'h07, 8'h07);
        swap();
        play(0, 255, 8'h07, 8'h07);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
